// File: rtl/line_pkg.sv
// line_pkg: shared types and defaults for the line-engine command scheduler
//   XW, YW         default X/Y coordinate widths (match Xpos/Ypos)
//   line_cmd_t     one segment command {x0, y0, x1, y1}
//   sched_state_t  sequencer states {IDLE, START, RUN}
package line_pkg;
    localparam int XW = 11;
    localparam int YW = 10;

    typedef struct packed {
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [XW-1:0] x1;
        logic [YW-1:0] y1;
    } line_cmd_t;

    typedef enum logic [1:0] {IDLE, START, RUN} sched_state_t;
endpackage

// File: rtl/line_cmd_fifo.sv
// line_cmd_fifo: DEPTH-entry command queue with synchronous push/pop/flush
//   clk, reset  clock, asynchronous active-low reset
//   push, din   write din at the tail (ignored when full or flushing)
//   pop         advance the head (ignored when empty or flushing)
//   flush       empty the queue on the next edge
//   head        current head entry (valid while count != 0)
//   count       number of queued entries
module line_cmd_fifo
    import line_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  line_cmd_t              din,
    output line_cmd_t              head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    line_cmd_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           do_push, do_pop;

    assign do_push = push && !flush && count != CW'(DEPTH);
    assign do_pop  = pop && !flush && count != '0;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/line_sched.sv
// line_sched: two-port round-robin command scheduler for the Bresenham line engine
//   clk, reset             pixel clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (ready is one-hot or zero)
//   req_x0/y0/x1/y1        per-requester segment endpoints
//   flush                  discard queued commands (in-flight segment still completes)
//   eng_start              one-cycle start pulse to the engine
//   eng_x0/y0/x1/y1        endpoints held for the engine
//   eng_done               engine completion, honoured only in RUN
//   busy                   queue non-empty or a segment in progress
//   fifo_count             queued commands
//   line_count             completed segments (wraps)
module line_sched #(
    parameter int XW    = line_pkg::XW,
    parameter int YW    = line_pkg::YW,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][XW-1:0]     req_x0,
    input  logic [1:0][XW-1:0]     req_x1,
    input  logic [1:0][YW-1:0]     req_y0,
    input  logic [1:0][YW-1:0]     req_y1,
    input  logic                   flush,
    output logic                   eng_start,
    output logic [XW-1:0]          eng_x0,
    output logic [XW-1:0]          eng_x1,
    output logic [YW-1:0]          eng_y0,
    output logic [YW-1:0]          eng_y1,
    input  logic                   eng_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            line_count
);
    import line_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    sched_state_t state, state_nxt;
    line_cmd_t    push_cmd, head;
    logic [1:0]   cand, grant;
    logic         rr_last, push, pop, full, empty;

    assign full  = fifo_count == CW'(DEPTH);
    assign empty = fifo_count == '0;

    // ready is held low while reset is asserted, even though full reads as 0
    assign cand      = req_valid & {2{reset && !full && !flush}};
    // on contention the requester not served last wins
    assign grant     = cand == 2'b11 ? (rr_last ? 2'b01 : 2'b10) : cand;
    assign req_ready = grant;
    assign push      = |grant;
    assign push_cmd  = grant[1] ? {req_x0[1], req_y0[1], req_x1[1], req_y1[1]}
                                : {req_x0[0], req_y0[0], req_x1[0], req_y1[0]};

    line_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_cmd),
        .head  (head),
        .count (fifo_count)
    );

    // head is taken when idle, or back-to-back on the done edge
    assign pop  = !flush && !empty && (state == IDLE || (state == RUN && eng_done));
    assign busy = !empty || state != IDLE;

    always_comb begin
        eng_start = state == START;
        state_nxt = state == START                 ? RUN
                  : pop                            ? START
                  : (state == RUN && eng_done)     ? IDLE
                  : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr_last    <= 1'b1;
            line_count <= '0;
            eng_x0     <= '0;
            eng_y0     <= '0;
            eng_x1     <= '0;
            eng_y1     <= '0;
        end else begin
            state <= state_nxt;
            if (push) rr_last <= grant[1];
            if (state == RUN && eng_done) line_count <= line_count + 16'd1;
            if (pop) begin
                eng_x0 <= head.x0;
                eng_y0 <= head.y0;
                eng_x1 <= head.x1;
                eng_y1 <= head.y1;
            end
        end
    end
endmodule

// File: tb/tb_line_sched.sv
// tb_line_sched: randomized self-checking bench for line_sched against a queue-based reference
module tb_line_sched;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int DEPTH = 4;
    localparam int P_IDLE = 0;
    localparam int P_START = 1;
    localparam int P_RUN = 2;

    typedef struct packed {
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [XW-1:0] x1;
        logic [YW-1:0] y1;
    } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_ready;
    logic [1:0][XW-1:0] req_x0 = '0;
    logic [1:0][XW-1:0] req_x1 = '0;
    logic [1:0][YW-1:0] req_y0 = '0;
    logic [1:0][YW-1:0] req_y1 = '0;
    logic flush = 1'b0;
    logic eng_done = 1'b0;
    logic eng_start, busy;
    logic [XW-1:0] eng_x0, eng_x1;
    logic [YW-1:0] eng_y0, eng_y1;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0] line_count;

    line_sched #(.XW(XW), .YW(YW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x0     (req_x0),
        .req_x1     (req_x1),
        .req_y0     (req_y0),
        .req_y1     (req_y1),
        .flush      (flush),
        .eng_start  (eng_start),
        .eng_x0     (eng_x0),
        .eng_x1     (eng_x1),
        .eng_y0     (eng_y0),
        .eng_y1     (eng_y1),
        .eng_done   (eng_done),
        .busy       (busy),
        .fifo_count (fifo_count),
        .line_count (line_count)
    );

    always #5 clk = ~clk;

    // reference: queued commands, segment in the engine, phase, round-robin memory, count
    cmd_t mq[$];
    cmd_t mcur;
    int   mph;
    bit   mrr;
    int   mlc;
    int   checks, fails, edge_n, start_edge, run_cnt, eng_lat;
    bit   auto_eng;
    bit [1:0] last_ready;
    int   obs_grants[$];

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.x0 = XW'($urandom_range(0, 1919));
        c.y0 = YW'($urandom_range(0, 1079));
        c.x1 = XW'($urandom_range(0, 1919));
        c.y1 = YW'($urandom_range(0, 1079));
        return c;
    endfunction

    task automatic set_cmd(input int r, input cmd_t c);
        req_x0[r] = c.x0;
        req_y0[r] = c.y0;
        req_x1[r] = c.x1;
        req_y1[r] = c.y1;
    endtask

    task automatic model_reset();
        mq.delete();
        mcur = '0;
        mph = P_IDLE;
        mrr = 1'b1;
        mlc = 0;
        run_cnt = 0;
    endtask

    // one clock: check ready before the edge, advance the reference at the edge, check outputs after
    task automatic step();
        bit [1:0] er;
        bit d, f;
        cmd_t c0, c1;
        if (auto_eng) eng_done = (mph == P_RUN) && (run_cnt >= eng_lat);
        @(negedge clk);
        er = 2'b00;
        if (reset && !flush && mq.size() < DEPTH)
            er = (req_valid == 2'b11) ? (mrr ? 2'b01 : 2'b10) : req_valid;
        last_ready = req_ready;
        if (req_ready != 2'b00) obs_grants.push_back(int'(req_ready[1]));
        checks++;
        if (req_ready !== er) begin
            fails++;
            $display("FAIL req_ready edge %0d: got %b expected %b", edge_n + 1, req_ready, er);
        end
        d = eng_done;
        f = flush;
        c0 = {req_x0[0], req_y0[0], req_x1[0], req_y1[0]};
        c1 = {req_x0[1], req_y0[1], req_x1[1], req_y1[1]};
        @(posedge clk);
        edge_n++;
        if (!reset) model_reset();
        else begin
            if (mph == P_START) begin
                mph = P_RUN;
                run_cnt = 1;
            end else if (mph == P_RUN && !d) run_cnt++;
            else begin
                if (mph == P_RUN) mlc = (mlc + 1) % 65536;
                if (mq.size() > 0 && !f) begin
                    mcur = mq.pop_front();
                    mph = P_START;
                end else mph = P_IDLE;
            end
            if (er != 2'b00) begin
                mq.push_back(er[1] ? c1 : c0);
                mrr = er[1];
            end
            if (f) mq.delete();
        end
        #1;
        checks += 5;
        if (eng_start !== (mph == P_START)) begin
            fails++;
            $display("FAIL eng_start edge %0d: got %b expected %b", edge_n, eng_start, mph == P_START);
        end
        if (int'(fifo_count) !== mq.size()) begin
            fails++;
            $display("FAIL fifo_count edge %0d: got %0d expected %0d", edge_n, fifo_count, mq.size());
        end
        if (busy !== (mq.size() > 0 || mph != P_IDLE)) begin
            fails++;
            $display("FAIL busy edge %0d: got %b expected %b", edge_n, busy, mq.size() > 0 || mph != P_IDLE);
        end
        if (line_count !== 16'(mlc)) begin
            fails++;
            $display("FAIL line_count edge %0d: got %0d expected %0d", edge_n, line_count, mlc);
        end
        if ({eng_x0, eng_y0, eng_x1, eng_y1} !== mcur) begin
            fails++;
            $display("FAIL endpoints edge %0d: got %h expected %h", edge_n, {eng_x0, eng_y0, eng_x1, eng_y1}, mcur);
        end
        if (eng_start === 1'b1) start_edge = edge_n;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int n = 0; n < budget && (busy !== 1'b0 || mph != P_IDLE); n++) step();
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_drain: busy=%b after %0d cycles, expected 0", tag, busy, budget);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        reset = 1'b0;
        req_valid = 2'b11;
        step();
        step();
        checks += 3;
        if (line_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_line_count: got %0d expected 0", line_count);
        end
        if (fifo_count !== '0) begin
            fails++;
            $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count);
        end
        if ({eng_start, busy} !== 2'b00) begin
            fails++;
            $display("FAIL reset_start_busy: got %b expected 00", {eng_start, busy});
        end
        req_valid = 2'b00;
        reset = 1'b1;
    endtask

    task automatic test_single();
        cmd_t c;
        int e0;
        c.x0 = '0;
        c.y0 = '0;
        c.x1 = 11'd300;
        c.y1 = 10'd300;
        auto_eng = 1'b1;
        eng_lat = 600;
        start_edge = -1;
        set_cmd(0, c);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        e0 = edge_n;
        checks++;
        if (last_ready !== 2'b01) begin
            fails++;
            $display("FAIL single_accept: got ready %b expected 01", last_ready);
        end
        for (int i = 0; i < 8 && start_edge < 0; i++) step();
        // accept on edge e0, pop on e0+1, start visible right after e0+1
        checks += 2;
        if (start_edge != e0 + 1) begin
            fails++;
            $display("FAIL single_latency: start after edge %0d expected %0d", start_edge, e0 + 1);
        end
        if ({eng_x0, eng_y0, eng_x1, eng_y1} !== {11'd0, 10'd0, 11'd300, 10'd300}) begin
            fails++;
            $display("FAIL single_endpoints: got %0d,%0d->%0d,%0d expected 0,0->300,300", eng_x0, eng_y0, eng_x1, eng_y1);
        end
        wait_idle(700, "single");
        checks++;
        if (line_count !== 16'd1) begin
            fails++;
            $display("FAIL single_count: got %0d expected 1", line_count);
        end
    endtask

    task automatic test_contention();
        do_reset();
        auto_eng = 1'b0;
        eng_done = 1'b0;
        obs_grants.delete();
        req_valid = 2'b11;
        for (int n = 0; n < 12; n++) begin
            set_cmd(0, rand_cmd());
            set_cmd(1, rand_cmd());
            step();
            if (last_ready == 2'b00) break;
        end
        step();
        checks += 3;
        if (obs_grants.size() < 4 || obs_grants[0] != 0 || obs_grants[1] != 1 || obs_grants[2] != 0 || obs_grants[3] != 1) begin
            fails++;
            $display("FAIL contention_order: got %p expected 0,1,0,1 first", obs_grants);
        end
        if (fifo_count !== 3'd4) begin
            fails++;
            $display("FAIL contention_full: got count %0d expected 4", fifo_count);
        end
        if (last_ready !== 2'b00) begin
            fails++;
            $display("FAIL contention_ready_full: got %b expected 00", last_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_full_done();
        set_cmd(0, rand_cmd());
        req_valid = 2'b01;
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        checks += 2;
        if (last_ready !== 2'b00) begin
            fails++;
            $display("FAIL full_done_ready: got %b expected 00", last_ready);
        end
        if (fifo_count !== 3'd3) begin
            fails++;
            $display("FAIL full_done_pop: got count %0d expected 3", fifo_count);
        end
        step();
        req_valid = 2'b00;
        checks += 2;
        if (last_ready !== 2'b01) begin
            fails++;
            $display("FAIL full_done_accept: got %b expected 01", last_ready);
        end
        if (fifo_count !== 3'd4) begin
            fails++;
            $display("FAIL full_done_refill: got count %0d expected 4", fifo_count);
        end
        auto_eng = 1'b1;
        eng_lat = 3;
        wait_idle(200, "full_done");
    endtask

    task automatic test_flush();
        int lc;
        auto_eng = 1'b0;
        eng_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(1, rand_cmd());
            req_valid = 2'b10;
            step();
        end
        req_valid = 2'b00;
        step();
        step();
        lc = mlc;
        checks++;
        if (fifo_count !== 3'd3) begin
            fails++;
            $display("FAIL flush_setup: got count %0d expected 3", fifo_count);
        end
        flush = 1'b1;
        req_valid = 2'b11;
        step();
        flush = 1'b0;
        req_valid = 2'b00;
        checks += 2;
        if (last_ready !== 2'b00) begin
            fails++;
            $display("FAIL flush_ready: got %b expected 00", last_ready);
        end
        if (fifo_count !== '0) begin
            fails++;
            $display("FAIL flush_count: got %0d expected 0", fifo_count);
        end
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        checks++;
        if (line_count !== 16'(lc + 1)) begin
            fails++;
            $display("FAIL flush_completes: got %0d expected %0d", line_count, lc + 1);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (eng_start !== 1'b0) begin
                fails++;
                $display("FAIL flush_no_start: got %b expected 0", eng_start);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_spurious();
        int lc;
        auto_eng = 1'b0;
        lc = mlc;
        eng_done = 1'b1;
        step();
        step();
        eng_done = 1'b0;
        checks++;
        if (line_count !== 16'(lc)) begin
            fails++;
            $display("FAIL spurious_idle: got %0d expected %0d", line_count, lc);
        end
        set_cmd(0, rand_cmd());
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        checks++;
        if (eng_start !== 1'b1) begin
            fails++;
            $display("FAIL spurious_start: got %b expected 1", eng_start);
        end
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        checks += 2;
        if (line_count !== 16'(lc)) begin
            fails++;
            $display("FAIL spurious_in_start: got %0d expected %0d", line_count, lc);
        end
        if ({eng_start, busy} !== 2'b01) begin
            fails++;
            $display("FAIL spurious_run: start/busy got %b expected 01", {eng_start, busy});
        end
        step();
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        checks++;
        if (line_count !== 16'(lc + 1)) begin
            fails++;
            $display("FAIL spurious_real_done: got %0d expected %0d", line_count, lc + 1);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL spurious_idle_after: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_async_reset();
        auto_eng = 1'b1;
        eng_lat = 50;
        set_cmd(0, rand_cmd());
        set_cmd(1, rand_cmd());
        req_valid = 2'b11;
        step();
        step();
        step();
        req_valid = 2'b00;
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        #2;
        reset = 1'b0;
        req_valid = 2'b11;
        #1;
        checks += 3;
        if ({req_ready, eng_start, busy} !== 4'b0000) begin
            fails++;
            $display("FAIL async_ctrl: ready/start/busy got %b expected 0000", {req_ready, eng_start, busy});
        end
        if (fifo_count !== '0 || line_count !== 16'd0) begin
            fails++;
            $display("FAIL async_counts: fifo %0d line %0d expected 0 0", fifo_count, line_count);
        end
        if ({eng_x0, eng_y0, eng_x1, eng_y1} !== '0) begin
            fails++;
            $display("FAIL async_endpoints: got %h expected 0", {eng_x0, eng_y0, eng_x1, eng_y1});
        end
        model_reset();
        step();
        step();
        reset = 1'b1;
        req_valid = 2'b01;
        set_cmd(0, rand_cmd());
        step();
        req_valid = 2'b00;
        checks++;
        if (last_ready !== 2'b01) begin
            fails++;
            $display("FAIL async_accept: got %b expected 01", last_ready);
        end
        eng_lat = 4;
        wait_idle(100, "async");
        checks++;
        if (line_count !== 16'd1) begin
            fails++;
            $display("FAIL async_restart_count: got %0d expected 1", line_count);
        end
    endtask

    task automatic test_random();
        auto_eng = 1'b1;
        for (int i = 0; i < 400; i++) begin
            req_valid = 2'($urandom);
            set_cmd(0, rand_cmd());
            set_cmd(1, rand_cmd());
            flush = $urandom_range(0, 24) == 0;
            eng_lat = $urandom_range(1, 6);
            step();
        end
        req_valid = 2'b00;
        flush = 1'b0;
        wait_idle(200, "random");
    endtask

    initial begin
        checks = 0;
        fails = 0;
        edge_n = 0;
        auto_eng = 1'b0;
        eng_lat = 1;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_full_done();
        test_flush();
        test_spurious();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end
endmodule
